// File: rtl/seg_scan_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_clkgen
// Purpose  : Multiplexed 7-segment scanner with frame-synchronous loading and
//            an independent 50% duty slow clock.
// Option   : SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0
// ============================================================================
module seg_scan_clkgen #(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 250000,
    parameter int SLOW_DIV = 512
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*N_DIGITS-1:0] i_digits,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic                  i_load,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_an,
    output logic                  o_pend,
    output logic                  o_clk
);

    localparam int c_scan_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_slow_w = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam int c_idx_w  = $clog2(N_DIGITS);

    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_slow_w-1:0] c_slow_last = c_slow_w'(SLOW_DIV - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] c_an_one    = N_DIGITS'(1);

    logic [c_scan_w-1:0]   r_scan_cnt;
    logic [c_slow_w-1:0]   r_slow_cnt;
    logic [c_idx_w-1:0]    r_idx;
    logic [4*N_DIGITS-1:0] r_disp_digits;
    logic [N_DIGITS-1:0]   r_disp_dp;
    logic [4*N_DIGITS-1:0] r_pend_digits;
    logic [N_DIGITS-1:0]   r_pend_dp;
    logic                  r_pend;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [N_DIGITS-1:0]   r_an;
    logic                  r_clk;

    logic                  w_scan_tick;
    logic                  w_frame_tick;
    logic [3:0]            w_nib;
    logic [N_DIGITS-1:0]   w_blank;

    function automatic logic [6:0] f_seg(input logic [3:0] nib);
        logic [6:0] v_seg;
        case (nib)
            4'h0:    v_seg = 7'h3F;
            4'h1:    v_seg = 7'h06;
            4'h2:    v_seg = 7'h5B;
            4'h3:    v_seg = 7'h4F;
            4'h4:    v_seg = 7'h66;
            4'h5:    v_seg = 7'h6D;
            4'h6:    v_seg = 7'h7D;
            4'h7:    v_seg = 7'h07;
            4'h8:    v_seg = 7'h7F;
            4'h9:    v_seg = 7'h6F;
            4'hA:    v_seg = 7'h77;
            4'hB:    v_seg = 7'h7C;
            4'hC:    v_seg = 7'h58;
            4'hD:    v_seg = 7'h5E;
            4'hE:    v_seg = 7'h79;
            default: v_seg = 7'h71;
        endcase
        return v_seg;
    endfunction

    assign w_scan_tick  = (r_scan_cnt == c_scan_last);
    assign w_frame_tick = w_scan_tick && (r_idx == c_idx_last);
    assign w_nib        = r_disp_digits[{r_idx, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic w_upper_zero;

    // A digit blanks when it and every digit above it are zero; digit 0 never.
    always_comb begin
        w_blank      = '0;
        w_upper_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            w_upper_zero = w_upper_zero & (r_disp_digits[4*k +: 4] == 4'h0);
            w_blank[k]   = w_upper_zero;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scan_cnt    <= '0;
            r_slow_cnt    <= '0;
            r_idx         <= '0;
            r_disp_digits <= '0;
            r_disp_dp     <= '0;
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend        <= 1'b0;
            r_seg         <= '0;
            r_dp          <= 1'b0;
            r_an          <= '0;
            r_clk         <= 1'b0;
        end else begin
            r_scan_cnt <= w_scan_tick ? '0 : r_scan_cnt + 1'b1;
            if (w_scan_tick) begin
                r_idx <= w_frame_tick ? '0 : r_idx + 1'b1;
            end

            // A load landing on the frame boundary bypasses the pending stage.
            if (i_load && w_frame_tick) begin
                r_disp_digits <= i_digits;
                r_disp_dp     <= i_dp;
                r_pend        <= 1'b0;
            end else begin
                if (w_frame_tick && r_pend) begin
                    r_disp_digits <= r_pend_digits;
                    r_disp_dp     <= r_pend_dp;
                    r_pend        <= 1'b0;
                end
                if (i_load) begin
                    r_pend_digits <= i_digits;
                    r_pend_dp     <= i_dp;
                    r_pend        <= 1'b1;
                end
            end

            // Outputs follow the registered index one cycle later.
            r_an  <= c_an_one << r_idx;
            r_seg <= w_blank[r_idx] ? 7'h00 : f_seg(w_nib);
            r_dp  <= r_disp_dp[r_idx];

            if (r_slow_cnt == c_slow_last) begin
                r_slow_cnt <= '0;
                r_clk      <= ~r_clk;
            end else begin
                r_slow_cnt <= r_slow_cnt + 1'b1;
            end
        end
    end

    assign o_seg  = r_seg;
    assign o_dp   = r_dp;
    assign o_an   = r_an;
    assign o_pend = r_pend;
    assign o_clk  = r_clk;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_clkgen
// Purpose  : Directed self-checking bench for seg_scan_clkgen (4 digits,
//            SCAN_DIV=4, SLOW_DIV=3).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_seg_scan_clkgen;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        load;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic        pend;
    logic        slow_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    seg_scan_clkgen #(
        .N_DIGITS (4),
        .SCAN_DIV (4),
        .SLOW_DIV (3)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_digits (digits),
        .i_dp     (dp),
        .i_load   (load),
        .o_seg    (seg),
        .o_dp     (seg_dp),
        .o_an     (an),
        .o_pend   (pend),
        .o_clk    (slow_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One rising edge, then settle at the falling edge; cyc counts edges since release.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; digits = '0; dp = '0;
        repeat (3) tick();
        n_tests++;
        if ({an, seg, seg_dp, pend, slow_clk} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got an=%h seg=%h dp=%b pend=%b clk=%b exp all 0",
                     an, seg, seg_dp, pend, slow_clk);
        end
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_an = 4'b0001 << (((k - 1) / 4) % 4);
            n_tests++;
            if (an !== exp_an || seg !== 7'h3F) begin
                n_fail++;
                $display("FAIL scan k=%0d got an=%h seg=%h exp an=%h seg=3f", k, an, seg, exp_an);
            end
        end
    endtask

    task automatic test_load_midframe();
        digits = 16'h12AF; dp = 4'b0100; load = 1'b1;
        tick();
        load = 1'b0;
        n_tests++;
        if (pend !== 1'b1) begin
            n_fail++; $display("FAIL mid_pend_set got %b exp 1", pend);
        end
        run_to(29);
        n_tests++;
        if (pend !== 1'b1 || an !== 4'h8 || seg !== 7'h3F) begin
            n_fail++;
            $display("FAIL mid_hold got pend=%b an=%h seg=%h exp 1 8 3f", pend, an, seg);
        end
        run_to(32);
        n_tests++;
        if (pend !== 1'b0) begin
            n_fail++; $display("FAIL mid_pend_clear got %b exp 0", pend);
        end
        run_to(33);
        n_tests++;
        if (an !== 4'h1 || seg !== 7'h71 || seg_dp !== 1'b0) begin
            n_fail++; $display("FAIL mid_d0 got an=%h seg=%h dp=%b exp 1 71 0", an, seg, seg_dp);
        end
        run_to(37);
        n_tests++;
        if (an !== 4'h2 || seg !== 7'h77 || seg_dp !== 1'b0) begin
            n_fail++; $display("FAIL mid_d1 got an=%h seg=%h dp=%b exp 2 77 0", an, seg, seg_dp);
        end
        run_to(41);
        n_tests++;
        if (an !== 4'h4 || seg !== 7'h5B || seg_dp !== 1'b1) begin
            n_fail++; $display("FAIL mid_d2 got an=%h seg=%h dp=%b exp 4 5b 1", an, seg, seg_dp);
        end
        run_to(45);
        n_tests++;
        if (an !== 4'h8 || seg !== 7'h06 || seg_dp !== 1'b0) begin
            n_fail++; $display("FAIL mid_d3 got an=%h seg=%h dp=%b exp 8 06 0", an, seg, seg_dp);
        end
    endtask

    task automatic test_load_boundary();
        run_to(47);
        digits = 16'h0005; dp = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        n_tests++;
        if (pend !== 1'b0) begin
            n_fail++; $display("FAIL bnd_pend got %b exp 0", pend);
        end
        run_to(49);
        n_tests++;
        if (an !== 4'h1 || seg !== 7'h6D || pend !== 1'b0) begin
            n_fail++; $display("FAIL bnd_d0 got an=%h seg=%h pend=%b exp 1 6d 0", an, seg, pend);
        end
        run_to(53);
        n_tests++;
        if (an !== 4'h2 || seg !== 7'h3F) begin
            n_fail++; $display("FAIL bnd_d1 got an=%h seg=%h exp 2 3f", an, seg);
        end
    endtask

    task automatic test_back_to_back();
        digits = 16'h1111; load = 1'b1;
        tick();
        load = 1'b0;
        n_tests++;
        if (pend !== 1'b1) begin
            n_fail++; $display("FAIL b2b_pend1 got %b exp 1", pend);
        end
        run_to(56);
        digits = 16'h2222; load = 1'b1;
        tick();
        load = 1'b0;
        n_tests++;
        if (pend !== 1'b1) begin
            n_fail++; $display("FAIL b2b_pend2 got %b exp 1", pend);
        end
        run_to(61);
        n_tests++;
        if (an !== 4'h8 || seg !== 7'h3F) begin
            n_fail++; $display("FAIL b2b_old_frame got an=%h seg=%h exp 8 3f", an, seg);
        end
        for (int d = 0; d < 4; d++) begin
            run_to(65 + 4 * d);
            n_tests++;
            if (an !== (4'b0001 << d) || seg !== 7'h5B || pend !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_d%0d got an=%h seg=%h pend=%b exp an=%h seg=5b pend=0",
                         d, an, seg, pend, 4'b0001 << d);
            end
        end
    endtask

    task automatic test_slow_clk();
        logic exp_clk;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_clk = ((cyc / 3) % 2) != 0;
            n_tests++;
            if (slow_clk !== exp_clk) begin
                n_fail++; $display("FAIL slow_clk cyc=%0d got %b exp %b", cyc, slow_clk, exp_clk);
            end
        end
    endtask

    task automatic test_reset_midframe();
        digits = 16'h8888; dp = 4'b1111; load = 1'b1;
        tick();
        load = 1'b0;
        n_tests++;
        if (pend !== 1'b1) begin
            n_fail++; $display("FAIL rstm_pend_pre got %b exp 1", pend);
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({an, seg, seg_dp, pend, slow_clk} !== 15'h0) begin
            n_fail++;
            $display("FAIL rstm_outputs got an=%h seg=%h dp=%b pend=%b clk=%b exp all 0",
                     an, seg, seg_dp, pend, slow_clk);
        end
        rst_n = 1'b1;
        cyc   = 0;
        tick();
        n_tests++;
        if (an !== 4'h1 || seg !== 7'h3F || pend !== 1'b0) begin
            n_fail++; $display("FAIL rstm_first got an=%h seg=%h pend=%b exp 1 3f 0", an, seg, pend);
        end
        run_to(17);
        n_tests++;
        if (an !== 4'h1 || seg !== 7'h3F || seg_dp !== 1'b0) begin
            n_fail++; $display("FAIL rstm_discard got an=%h seg=%h dp=%b exp 1 3f 0", an, seg, seg_dp);
        end
    endtask

    task automatic test_blank();
        logic [6:0] exp_hi;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        exp_hi = 7'h00;
`else
        exp_hi = 7'h3F;
`endif
        run_to(31);
        digits = 16'h0070; dp = 4'b1000; load = 1'b1;
        tick();
        load = 1'b0;
        run_to(33);
        n_tests++;
        if (an !== 4'h1 || seg !== 7'h3F) begin
            n_fail++; $display("FAIL blank_d0 got an=%h seg=%h exp 1 3f", an, seg);
        end
        run_to(37);
        n_tests++;
        if (an !== 4'h2 || seg !== 7'h07) begin
            n_fail++; $display("FAIL blank_d1 got an=%h seg=%h exp 2 07", an, seg);
        end
        run_to(41);
        n_tests++;
        if (an !== 4'h4 || seg !== exp_hi || seg_dp !== 1'b0) begin
            n_fail++; $display("FAIL blank_d2 got an=%h seg=%h dp=%b exp 4 %h 0", an, seg, seg_dp, exp_hi);
        end
        run_to(45);
        n_tests++;
        if (an !== 4'h8 || seg !== exp_hi || seg_dp !== 1'b1) begin
            n_fail++; $display("FAIL blank_d3 got an=%h seg=%h dp=%b exp 8 %h 1", an, seg, seg_dp, exp_hi);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        load   = 1'b0;
        digits = '0;
        dp     = '0;
        test_reset();
        test_scan();
        test_load_midframe();
        test_load_boundary();
        test_back_to_back();
        test_slow_clk();
        test_reset_midframe();
        test_blank();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_clkgen.md
SEG_SCAN_CLKGEN -- requirements
Module: seg_scan_clkgen

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed 7-segment digits (legal 2..8).
REQ-002 Parameter SCAN_DIV, default 250000, i_clk cycles each digit is displayed (legal >= 2).
REQ-003 Parameter SLOW_DIV, default 512, i_clk cycles per half-period of o_clk (legal >= 1).
REQ-004 i_clk  input  1  single system clock, 100 MHz; all logic on rising edge.
REQ-005 i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 i_digits  input  4*N_DIGITS  hex value per digit; digit k in bits [4k+3:4k]; digit 0 is least significant.
REQ-007 i_dp  input  N_DIGITS  decimal-point request per digit.
REQ-008 i_load  input  1  one-cycle strobe; captures i_digits and i_dp.
REQ-009 o_seg  output  7  segment pattern, bit0=a .. bit6=g, active-high.
REQ-010 o_dp  output  1  decimal point for the active digit, active-high.
REQ-011 o_an  output  N_DIGITS  one-hot digit enable, active-high.
REQ-012 o_pend  output  1  high while a captured value is waiting for the frame boundary.
REQ-013 o_clk  output  1  slow clock, 50% duty, period 2*SLOW_DIV i_clk cycles.

Function
REQ-014 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; the terminal count is the scan tick.
REQ-015 Digit index SHALL advance by 1 on each scan tick; at N_DIGITS-1 it SHALL wrap to 0 (frame boundary).
REQ-016 o_an, o_seg and o_dp SHALL be registered and SHALL reflect the new digit index on the cycle after the scan tick.
REQ-017 o_seg SHALL use the full 0-F map: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,c=58,d=5E,E=79,F=71 (hex, bit6..bit0).
REQ-018 i_load SHALL capture i_digits/i_dp into a pending register and set o_pend the following cycle.
REQ-019 On a frame-boundary tick with o_pend high, the pending value SHALL move to the display register and o_pend SHALL clear; the display never changes mid-frame.
REQ-020 i_load coincident with a frame-boundary tick SHALL load i_digits/i_dp directly into the display register; o_pend SHALL be low afterwards.
REQ-021 A second i_load while o_pend is high SHALL overwrite the pending value (last write wins); o_pend stays high.
REQ-022 o_clk SHALL toggle every SLOW_DIV cycles from an independent counter, unaffected by i_load or scanning.

Reset
REQ-023 While i_rst_n is low at a rising edge: all counters=0, digit index=0, display and pending registers=0, o_pend=0, o_clk=0, o_an=0, o_seg=0, o_dp=0.
REQ-024 First edge with i_rst_n high SHALL drive o_an=1 (digit 0) and o_seg=3F.
REQ-025 Reset asserted mid-frame or with o_pend high SHALL discard the pending value and restart from REQ-023.

Configuration
REQ-026 Macro SEG_LEADING_ZERO_BLANK_EN: when defined, any digit above the most significant non-zero digit of the display register SHALL output o_seg=00 and o_dp=i_dp bit (o_an unchanged); digit 0 is never blanked.
REQ-027 Without SEG_LEADING_ZERO_BLANK_EN, all digits SHALL display per REQ-017.

Verification
REQ-028 N_DIGITS=4, SCAN_DIV=4, release reset -> o_an sequence 1,2,4,8,1 each held 4 cycles; o_seg=3F throughout.
REQ-029 i_load with i_digits=16'h12AF mid-frame -> o_pend=1 until next frame boundary; then digits 0..3 show 71,77,5B,06.
REQ-030 i_load exactly on frame-boundary tick with 16'h0005 -> o_pend stays 0; next frame digit 0 shows 6D.
REQ-031 Two i_loads (16'h1111 then 16'h2222) in one frame -> next frame shows 5B on all digits.
REQ-032 SLOW_DIV=3 -> o_clk period 6 cycles; assert i_rst_n low mid-frame -> all outputs 0 on next edge, o_pend=0.
REQ-033 SEG_LEADING_ZERO_BLANK_EN defined, display 16'h0070 -> digits 3,2 show 00, digit1 shows 07, digit0 shows 3F.
